// File: rtl/div_scheduler_if.sv
// rtl/div_scheduler_if.sv - request, response and divider signal bundle for div_scheduler
interface div_scheduler_if #(
    parameter int W       = 8,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_dividend;
    logic [NUM_REQ*W-1:0] req_divisor;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [W-1:0]         resp_quotient;
    logic [W-1:0]         resp_remainder;
    logic                 resp_dbz;
    logic                 resp_timeout;

    logic                 div_start;
    logic [W-1:0]         div_dividend;
    logic [W-1:0]         div_divisor;
    logic                 div_clr;
    logic                 div_stop;
    logic [W-1:0]         div_quotient;
    logic [W-1:0]         div_remainder;

    modport slave (
        input  req_valid, req_dividend, req_divisor, resp_ready,
               div_stop, div_quotient, div_remainder,
        output req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
               resp_dbz, resp_timeout, div_start, div_dividend, div_divisor, div_clr
    );

    modport master (
        output req_valid, req_dividend, req_divisor, resp_ready,
               div_stop, div_quotient, div_remainder,
        input  req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
               resp_dbz, resp_timeout, div_start, div_dividend, div_divisor, div_clr
    );
endinterface

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - round-robin front end sharing one divider among NUM_REQ requesters
module div_scheduler #(
    parameter int W       = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    div_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic             gnt_any;
    logic [W-1:0]     gnt_dividend;
    logic [W-1:0]     gnt_divisor;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expire;

    // First valid requester strictly after rr_ptr, searching with wrap-around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_dividend = bus.req_dividend[gnt_idx*W +: W];
    assign gnt_divisor  = bus.req_divisor[gnt_idx*W +: W];
    assign wd_expire    = (wd_cnt == CNT_W'(TIMEOUT - 1));

    // rst_n gating keeps the accept strobe low while reset is held.
    assign bus.req_ready = (rst_n && state == IDLE && gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign bus.div_clr   = (state == WAIT) && !bus.div_stop && wd_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            rr_ptr             <= ID_W'(NUM_REQ - 1);
            wd_cnt             <= '0;
            bus.div_start      <= 1'b0;
            bus.div_dividend   <= '0;
            bus.div_divisor    <= '0;
            bus.resp_valid     <= 1'b0;
            bus.resp_id        <= '0;
            bus.resp_quotient  <= '0;
            bus.resp_remainder <= '0;
            bus.resp_dbz       <= 1'b0;
            bus.resp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        rr_ptr           <= gnt_idx;
                        bus.resp_id      <= gnt_idx;
                        bus.div_dividend <= gnt_dividend;
                        bus.div_divisor  <= gnt_divisor;
                        if (gnt_divisor == '0) begin
                            bus.resp_quotient  <= '1;
                            bus.resp_remainder <= gnt_dividend;
                            bus.resp_dbz       <= 1'b1;
                            bus.resp_valid     <= 1'b1;
                            state              <= RESP;
                        end else begin
                            bus.div_start <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    bus.div_start <= 1'b0;
                    wd_cnt        <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (bus.div_stop) begin
                        bus.resp_quotient  <= bus.div_quotient;
                        bus.resp_remainder <= bus.div_remainder;
                        bus.resp_valid     <= 1'b1;
                        state              <= RESP;
                    end else if (wd_expire) begin
                        bus.resp_quotient  <= '0;
                        bus.resp_remainder <= '0;
                        bus.resp_timeout   <= 1'b1;
                        bus.resp_valid     <= 1'b1;
                        state              <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid   <= 1'b0;
                        bus.resp_dbz     <= 1'b0;
                        bus.resp_timeout <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - self-checking bench for div_scheduler with a behavioural divider and scoreboard
module tb_div_scheduler;
    localparam int W       = 8;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_scheduler_if #(.W(W), .NUM_REQ(NUM_REQ)) bus ();

    div_scheduler #(.W(W), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int a;
        int b;
    } exp_t;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural divider: stops cur_delay cycles after div_start (negative or > TIMEOUT means hung).
    int   dm_delay   = 9;
    bit   dm_random  = 1'b0;
    bit   dm_busy    = 1'b0;
    int   dm_left    = 0;
    int   cur_delay  = 0;
    bit   cur_hang   = 1'b0;
    bit   inject_stop = 1'b0;
    int   rpick;
    int   dm_a, dm_b;
    int   stop_cyc   = 0;

    always @(negedge clk) begin
        bus.div_stop      = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        if (!rst_n) begin
            dm_busy = 1'b0;
        end else if (inject_stop) begin
            bus.div_stop      = 1'b1;
            bus.div_quotient  = 8'hA5;
            bus.div_remainder = 8'h5A;
            inject_stop       = 1'b0;
        end else if (bus.div_start) begin
            dm_busy = 1'b1;
            dm_a    = int'(bus.div_dividend);
            dm_b    = int'(bus.div_divisor);
            if (dm_random) begin
                rpick     = int'($urandom_range(0, 15));
                cur_delay = (rpick == 0) ? 70 : (rpick == 1) ? TIMEOUT : int'($urandom_range(1, 12));
            end else begin
                cur_delay = dm_delay;
            end
            dm_left  = cur_delay - 1;
            cur_hang = (cur_delay < 0) || (cur_delay > TIMEOUT);
        end else if (dm_busy && cur_delay >= 0) begin
            if (dm_left == 0) begin
                bus.div_stop      = 1'b1;
                bus.div_quotient  = W'(dm_a / dm_b);
                bus.div_remainder = W'(dm_a % dm_b);
                dm_busy           = 1'b0;
                stop_cyc          = cyc;
            end else begin
                dm_left--;
            end
        end
    end

    // Reference model: round-robin grant rule, one outstanding job, expected-response queue.
    function automatic int next_grant(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (((v >> ((last + k) % NUM_REQ)) & 1) != 0) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    exp_t exp_q[$];
    int   grant_log[$];
    bit   mon_en    = 1'b0;
    bit   mdl_busy  = 1'b0;
    int   rr_last   = NUM_REQ - 1;
    bit   acc_flag [NUM_REQ];
    int   acc_cyc = 0, start_cyc = 0, clr_cyc = 0;
    int   n_start = 0, n_clr = 0, n_resp = 0;
    int   last_id, last_q, last_r, last_dbz, last_to;
    bit   prev_hold = 1'b0;
    logic [31:0] prev_bits;
    int   g, exp_rdy, xq, xr, xd, xt;
    exp_t e;

    always begin
        @(negedge clk);
        #1;
        if (rst_n && mon_en) begin
            g       = mdl_busy ? -1 : next_grant(bus.req_valid, rr_last);
            exp_rdy = (g < 0) ? 0 : (1 << g);
            check_eq("req_ready", 32'(bus.req_ready), exp_rdy);
            if ((bus.req_ready & bus.req_valid) != '0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (((bus.req_ready >> i) & 1) != 0) begin
                        e.id = i;
                        e.a  = int'(bus.req_dividend[i*W +: W]);
                        e.b  = int'(bus.req_divisor[i*W +: W]);
                    end
                end
                exp_q.push_back(e);
                grant_log.push_back(e.id);
                acc_flag[e.id] = 1'b1;
                mdl_busy = 1'b1;
                rr_last  = e.id;
                acc_cyc  = cyc;
            end
            if (bus.div_start) begin
                n_start++;
                start_cyc = cyc;
                check_eq("start_lat", cyc - acc_cyc, 1);
                if (exp_q.size() > 0) begin
                    check_eq("div_dividend", 32'(bus.div_dividend), exp_q[0].a);
                    check_eq("div_divisor", 32'(bus.div_divisor), exp_q[0].b);
                end
            end
            if (bus.div_clr) begin
                n_clr++;
                clr_cyc = cyc;
                dm_busy = 1'b0;
                check_eq("clr_lat", cyc - start_cyc, TIMEOUT);
                check_eq("clr_hang", 32'(cur_hang), 1);
            end
            if (bus.resp_valid) begin
                if (prev_hold) begin
                    check_eq("resp_stable", 32'({bus.resp_id, bus.resp_quotient, bus.resp_remainder,
                                                 bus.resp_dbz, bus.resp_timeout}), prev_bits);
                end else if (exp_q.size() > 0) begin
                    if (exp_q[0].b == 0)   check_eq("resp_lat_dbz", cyc - acc_cyc, 1);
                    else if (cur_hang)     check_eq("resp_lat_to", cyc - clr_cyc, 1);
                    else                   check_eq("resp_lat", cyc - stop_cyc, 1);
                end
                if (bus.resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("resp_expected", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.b == 0) begin
                            xq = (1 << W) - 1; xr = e.a; xd = 1; xt = 0;
                        end else if (cur_hang) begin
                            xq = 0; xr = 0; xd = 0; xt = 1;
                        end else begin
                            xq = e.a / e.b; xr = e.a % e.b; xd = 0; xt = 0;
                        end
                        check_eq("resp_id", 32'(bus.resp_id), e.id);
                        check_eq("resp_quotient", 32'(bus.resp_quotient), xq);
                        check_eq("resp_remainder", 32'(bus.resp_remainder), xr);
                        check_eq("resp_dbz", 32'(bus.resp_dbz), xd);
                        check_eq("resp_timeout", 32'(bus.resp_timeout), xt);
                    end
                    last_id  = int'(bus.resp_id);
                    last_q   = int'(bus.resp_quotient);
                    last_r   = int'(bus.resp_remainder);
                    last_dbz = int'(bus.resp_dbz);
                    last_to  = int'(bus.resp_timeout);
                    mdl_busy = 1'b0;
                    n_resp++;
                end
            end else if (prev_hold) begin
                check_eq("resp_held", 32'(bus.resp_valid), 1);
            end
            prev_hold = bus.resp_valid && !bus.resp_ready;
            prev_bits = 32'({bus.resp_id, bus.resp_quotient, bus.resp_remainder,
                             bus.resp_dbz, bus.resp_timeout});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_flag[i]) begin
                bus.req_valid[i] = 1'b0;
                acc_flag[i]      = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid[i]          = 1'b1;
        bus.req_dividend[i*W +: W] = a;
        bus.req_divisor[i*W +: W]  = b;
    endtask

    task automatic drain(input int budget);
        int  n = 0;
        bit  idle;
        idle = !mdl_busy && exp_q.size() == 0 && bus.req_valid == '0;
        while (!idle && n < budget) begin
            step();
            n++;
            idle = !mdl_busy && exp_q.size() == 0 && bus.req_valid == '0;
        end
        check_eq("drain", 32'(idle), 1);
    endtask

    task automatic check_outputs_zero(input string p);
        check_eq({p, "_req_ready"}, 32'(bus.req_ready), 0);
        check_eq({p, "_resp_valid"}, 32'(bus.resp_valid), 0);
        check_eq({p, "_resp_id"}, 32'(bus.resp_id), 0);
        check_eq({p, "_resp_quotient"}, 32'(bus.resp_quotient), 0);
        check_eq({p, "_resp_remainder"}, 32'(bus.resp_remainder), 0);
        check_eq({p, "_resp_flags"}, 32'({bus.resp_dbz, bus.resp_timeout}), 0);
        check_eq({p, "_div_start"}, 32'(bus.div_start), 0);
        check_eq({p, "_div_clr"}, 32'(bus.div_clr), 0);
        check_eq({p, "_div_operands"}, 32'({bus.div_dividend, bus.div_divisor}), 0);
    endtask

    int s_start, s_clr, s_resp, n;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.resp_ready   = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) acc_flag[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Round-robin from reset, then a second round starting again at 0.
        dm_delay = 6;
        grant_log.delete();
        set_req(0, 200, 3); set_req(1, 50, 5); set_req(2, 9, 4); set_req(3, 255, 16);
        n = 0;
        while (grant_log.size() < 4 && n < 500) begin step(); n++; end
        set_req(0, 17, 2); set_req(1, 33, 4); set_req(2, 60, 7); set_req(3, 81, 9);
        n = 0;
        while (grant_log.size() < 5 && n < 500) begin step(); n++; end
        check_eq("rr_count", 32'(grant_log.size()), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) check_eq("rr_order", grant_log[k], exp_order[k]);
        drain(1000);

        // Single request from requester 2.
        dm_delay = 9;
        s_start  = n_start;
        set_req(2, 100, 7);
        drain(300);
        check_eq("single_starts", n_start - s_start, 1);
        check_eq("single_id", last_id, 2);
        check_eq("single_q", last_q, 14);
        check_eq("single_r", last_r, 2);
        check_eq("single_flags", {last_dbz[15:0], last_to[15:0]}, 0);

        // Divide by zero never starts the divider.
        s_start = n_start;
        set_req(1, 77, 0);
        drain(100);
        check_eq("dbz_starts", n_start - s_start, 0);
        check_eq("dbz_q", last_q, 255);
        check_eq("dbz_r", last_r, 77);
        check_eq("dbz_flag", last_dbz, 1);

        // Hung divider, then a normal request, then stop on the last allowed WAIT cycle.
        dm_delay = -1;
        s_clr    = n_clr;
        set_req(3, 10, 3);
        drain(300);
        check_eq("to_clr_count", n_clr - s_clr, 1);
        check_eq("to_flag", last_to, 1);
        check_eq("to_q", last_q, 0);
        check_eq("to_r", last_r, 0);
        dm_delay = 5;
        set_req(0, 99, 10);
        drain(100);
        check_eq("after_to_q", last_q, 9);
        check_eq("after_to_flag", last_to, 0);
        dm_delay = TIMEOUT;
        s_clr    = n_clr;
        set_req(2, 250, 25);
        drain(300);
        check_eq("edge_clr_count", n_clr - s_clr, 0);
        check_eq("edge_q", last_q, 10);
        check_eq("edge_flag", last_to, 0);

        // Backpressure with a spurious stop while the response is held.
        dm_delay       = 3;
        s_resp         = n_resp;
        bus.resp_ready = 1'b0;
        set_req(1, 200, 9);
        n = 0;
        while (!bus.resp_valid && n < 100) begin step(); n++; end
        check_eq("bp_resp_seen", 32'(bus.resp_valid), 1);
        set_req(2, 40, 6);
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 3) inject_stop = 1'b1;
        end
        bus.resp_ready = 1'b1;
        drain(200);
        check_eq("bp_resp_count", n_resp - s_resp, 2);
        check_eq("bp_last_id", last_id, 2);
        check_eq("bp_last_q", last_q, 6);

        // Asynchronous reset in the middle of WAIT abandons the job.
        dm_delay = -1;
        s_start  = n_start;
        set_req(1, 50, 5);
        n = 0;
        while (n_start == s_start && n < 50) begin step(); n++; end
        repeat (5) step();
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        set_req(0, 21, 4);
        set_req(2, 66, 8);
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        grant_log.delete();
        mdl_busy  = 1'b0;
        rr_last   = NUM_REQ - 1;
        prev_hold = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) acc_flag[i] = 1'b0;
        dm_delay = 4;
        s_resp   = n_resp;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        drain(300);
        check_eq("rst_resp_count", n_resp - s_resp, 2);
        check_eq("rst_grants", 32'(grant_log.size()), 2);
        if (grant_log.size() >= 2) begin
            check_eq("rst_first_grant", grant_log[0], 0);
            check_eq("rst_second_grant", grant_log[1], 2);
        end

        // Randomised traffic, random consumer stalls and random divider delays.
        dm_random = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
                    set_req(i, W'($urandom_range(0, 255)),
                            ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 255)));
            end
        end
        bus.resp_ready = 1'b1;
        dm_random      = 1'b0;
        dm_delay       = 4;
        drain(2000);
        check_eq("final_queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
